// File: rtl/atm_controller.sv
`default_nettype none
// ============================================================================
// Module      : atm_controller
// Description : ATM transaction controller. Validates a card session PIN,
//               performs one deposit or withdrawal, and holds the balance.
// Revision    : 1.0 - initial release
// ============================================================================
module atm_controller #(
    parameter logic [15:0] PIN             = 16'h4756,
    parameter logic [63:0] BALANCE_INICIAL = 64'd5000,
    parameter int          MAX_INTENTOS    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tarjeta_recibida,
    input  logic        digito_stb,
    input  logic [3:0]  digito,
    input  logic        tipo_trans,
    input  logic        monto_stb,
    input  logic [31:0] monto,
    output logic [63:0] balance,
    output logic        balance_actualizado,
    output logic        entregar_dinero,
    output logic        pin_incorrecto,
    output logic        advertencia,
    output logic        bloqueo,
    output logic        fondos_insuficientes
);

    localparam int                  c_ATT_W    = $clog2(MAX_INTENTOS + 1);
    localparam logic [c_ATT_W-1:0]  c_ATT_MAX  = c_ATT_W'(MAX_INTENTOS);
    localparam logic [c_ATT_W-1:0]  c_ATT_WARN = c_ATT_W'(MAX_INTENTOS - 1);
    localparam logic [c_ATT_W-1:0]  c_ATT_ONE  = c_ATT_W'(1);

    typedef enum logic [2:0] {
        ESPERANDO_TARJETA = 3'd0,
        VERIFICAR_PIN     = 3'd1,
        ESPERANDO_MONTO   = 3'd2,
        BLOQUEO           = 3'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic                 r_tarjeta_q;
    logic                 r_digito_q;
    logic                 r_monto_q;
    logic [15:0]          r_pin_sr;
    logic [15:0]          w_pin_sr_nx;
    logic [1:0]           r_cnt;
    logic [1:0]           w_cnt_nx;
    logic [c_ATT_W-1:0]   r_attempts;
    logic [c_ATT_W-1:0]   w_attempts_nx;
    logic [c_ATT_W-1:0]   w_attempts_inc;
    logic [63:0]          r_balance;
    logic [63:0]          w_balance_nx;
    logic                 r_act;
    logic                 w_act_nx;
    logic                 r_ent;
    logic                 w_ent_nx;
    logic                 r_pin_bad;
    logic                 w_pin_bad_nx;
    logic                 r_adv;
    logic                 w_adv_nx;
    logic                 r_blo;
    logic                 w_blo_nx;
    logic                 r_fon;
    logic                 w_fon_nx;

    logic                 w_ev_tarjeta;
    logic                 w_ev_digito;
    logic                 w_ev_monto;
    logic [15:0]          w_pin_full;
    logic [64:0]          w_sum;
    logic [63:0]          w_monto64;

    assign w_ev_tarjeta   = tarjeta_recibida & ~r_tarjeta_q;
    assign w_ev_digito    = digito_stb & ~r_digito_q;
    assign w_ev_monto     = monto_stb & ~r_monto_q;
    assign w_pin_full     = {r_pin_sr[11:0], digito};
    assign w_monto64      = {32'd0, monto};
    assign w_sum          = {1'b0, r_balance} + {1'b0, w_monto64};
    assign w_attempts_inc = r_attempts + c_ATT_ONE;

    always_comb begin
        w_state_nx    = r_state;
        w_pin_sr_nx   = r_pin_sr;
        w_cnt_nx      = r_cnt;
        w_attempts_nx = r_attempts;
        w_balance_nx  = r_balance;
        w_act_nx      = 1'b0;
        w_ent_nx      = 1'b0;
        w_pin_bad_nx  = 1'b0;
        w_fon_nx      = 1'b0;
        w_adv_nx      = r_adv;
        w_blo_nx      = r_blo;

        case (r_state)
            ESPERANDO_TARJETA: begin
                if (w_ev_tarjeta) begin
                    w_state_nx  = VERIFICAR_PIN;
                    w_cnt_nx    = 2'd0;
                    w_pin_sr_nx = 16'd0;
                end
            end
            VERIFICAR_PIN: begin
                if (w_ev_digito) begin
                    w_pin_sr_nx = w_pin_full;
                    w_cnt_nx    = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        if (w_pin_full == PIN) begin
                            w_state_nx    = ESPERANDO_MONTO;
                            w_attempts_nx = '0;
                            w_adv_nx      = 1'b0;
                        end else begin
                            w_pin_bad_nx  = 1'b1;
                            w_attempts_nx = w_attempts_inc;
                            if (w_attempts_inc == c_ATT_WARN) begin
                                w_adv_nx = 1'b1;
                            end
                            // Lockout takes effect on the same edge as the final mismatch pulse.
                            if (w_attempts_inc == c_ATT_MAX) begin
                                w_state_nx = BLOQUEO;
                                w_blo_nx   = 1'b1;
                                w_adv_nx   = 1'b0;
                            end
                        end
                    end
                end
            end
            ESPERANDO_MONTO: begin
                if (w_ev_monto) begin
                    w_state_nx = ESPERANDO_TARJETA;
                    if (!tipo_trans) begin
                        w_balance_nx = w_sum[64] ? {64{1'b1}} : w_sum[63:0];
                        w_act_nx     = 1'b1;
                    end else if (w_monto64 <= r_balance) begin
                        w_balance_nx = r_balance - w_monto64;
                        w_act_nx     = 1'b1;
                        w_ent_nx     = 1'b1;
                    end else begin
                        w_fon_nx = 1'b1;
                    end
                end
            end
            BLOQUEO: begin
                w_blo_nx = 1'b1;
                w_adv_nx = 1'b0;
            end
            default: begin
                w_state_nx = ESPERANDO_TARJETA;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ESPERANDO_TARJETA;
            r_tarjeta_q <= 1'b0;
            r_digito_q  <= 1'b0;
            r_monto_q   <= 1'b0;
            r_pin_sr    <= 16'd0;
            r_cnt       <= 2'd0;
            r_attempts  <= '0;
            r_balance   <= BALANCE_INICIAL;
            r_act       <= 1'b0;
            r_ent       <= 1'b0;
            r_pin_bad   <= 1'b0;
            r_adv       <= 1'b0;
            r_blo       <= 1'b0;
            r_fon       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_tarjeta_q <= tarjeta_recibida;
            r_digito_q  <= digito_stb;
            r_monto_q   <= monto_stb;
            r_pin_sr    <= w_pin_sr_nx;
            r_cnt       <= w_cnt_nx;
            r_attempts  <= w_attempts_nx;
            r_balance   <= w_balance_nx;
            r_act       <= w_act_nx;
            r_ent       <= w_ent_nx;
            r_pin_bad   <= w_pin_bad_nx;
            r_adv       <= w_adv_nx;
            r_blo       <= w_blo_nx;
            r_fon       <= w_fon_nx;
        end
    end

    assign balance              = r_balance;
    assign balance_actualizado  = r_act;
    assign entregar_dinero      = r_ent;
    assign pin_incorrecto       = r_pin_bad;
    assign advertencia          = r_adv;
    assign bloqueo              = r_blo;
    assign fondos_insuficientes = r_fon;

endmodule
`default_nettype wire
